// File: rtl/seg_msg_pkg.sv
// Shared definitions for the scrolling segment message sequencer:
// message length, 7-segment letter codes {a,b,c,d,e,f,g}, the message ROM
// and the sequencer state type.
// Optional feature macro: SEG_MSG_BLANK_GAP_EN adds a blank GAP state.
package seg_msg_pkg;

    localparam int MSG_LEN = 13;

    localparam logic [6:0] SEG_S = 7'b1011011;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_N = 7'b0010101;
    localparam logic [6:0] SEG_O = 7'b1111110;
    localparam logic [6:0] SEG_L = 7'b0001110;
    localparam logic [6:0] SEG_G = 7'b1011110;
    localparam logic [6:0] SEG_U = 7'b0111110;

    // Packed array: element 0 is the rightmost entry, so the list reads
    // backwards from the message S,E,n,O,L,G,U,L,G,O,n,U,L.
    localparam logic [MSG_LEN-1:0][6:0] MSG_ROM = {
        SEG_L, SEG_U, SEG_N, SEG_O, SEG_G, SEG_L, SEG_U,
        SEG_G, SEG_L, SEG_O, SEG_N, SEG_E, SEG_S
    };

`ifdef SEG_MSG_BLANK_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;
`else
    typedef enum logic {ST_IDLE, ST_SHOW} state_t;
`endif

    function automatic logic [3:0] next_idx(input logic [3:0] cur);
        return (cur == 4'(MSG_LEN - 1)) ? 4'd0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/seg_msg_sequencer_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, consecutive-cycle debouncer
// and rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [15:0] cnt_q, cnt_d;

    // Debounce: level follows the synced input only after an unbroken run of mismatches
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Synchronizer and debouncer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/seg_msg_sequencer.sv
// Scrolls the fixed 13-letter message on a 7-segment display, advancing on
// a debounced button press or, in auto mode, after a dwell time per letter.
// Optional feature macro: SEG_MSG_BLANK_GAP_EN inserts GAP_CYCLES of blank
// display between letters.
module seg_msg_sequencer
    import seg_msg_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] DWELL_CYCLES    = 24'd5000000
`ifdef SEG_MSG_BLANK_GAP_EN
    ,
    parameter logic [23:0] GAP_CYCLES      = 24'd500000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       auto,
    output logic [6:0] seg,
    output logic [3:0] idx,
    output logic       step
);

    logic        press;
    logic        auto_s1_q, auto_s2_q, auto_prev_q;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic        step_q, step_d;
    logic [23:0] dwell_q, dwell_d;
    logic        expire, advance;
`ifdef SEG_MSG_BLANK_GAP_EN
    logic [23:0] gap_q, gap_d;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn),
        .press   (press)
    );

    // Synchronize auto and keep its previous synced value to spot mode changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_s1_q   <= 1'b0;
            auto_s2_q   <= 1'b0;
            auto_prev_q <= 1'b0;
        end else begin
            auto_s1_q   <= auto;
            auto_s2_q   <= auto_s1_q;
            auto_prev_q <= auto_s2_q;
        end
    end

    // Dwell expiry only exists while a letter is shown in auto mode; a
    // coincident press and expiry collapse into one advance request.
    assign expire  = (state_q == ST_SHOW) && auto_s2_q && (dwell_q == DWELL_CYCLES - 24'd1);
    assign advance = press || expire;

    // Next-state, display and timer logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        step_d  = 1'b0;
        dwell_d = ((state_q == ST_SHOW) && auto_s2_q) ? dwell_q + 24'd1 : '0;
        if (auto_s2_q != auto_prev_q) begin
            dwell_d = '0;
        end
`ifdef SEG_MSG_BLANK_GAP_EN
        gap_d = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    state_d = ST_SHOW;
                    idx_d   = 4'd0;
                    seg_d   = MSG_ROM[0];
                    step_d  = 1'b1;
                    dwell_d = '0;
                end
            end
            ST_SHOW: begin
                if (advance) begin
                    idx_d   = next_idx(idx_q);
                    dwell_d = '0;
`ifdef SEG_MSG_BLANK_GAP_EN
                    state_d = ST_GAP;
                    seg_d   = '0;
                    gap_d   = '0;
`else
                    seg_d   = MSG_ROM[next_idx(idx_q)];
                    step_d  = 1'b1;
`endif
                end
            end
`ifdef SEG_MSG_BLANK_GAP_EN
            ST_GAP: begin
                // Presses are ignored here; only the gap counter moves on.
                if (gap_q == GAP_CYCLES - 24'd1) begin
                    state_d = ST_SHOW;
                    seg_d   = MSG_ROM[idx_q];
                    step_d  = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 24'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered outputs and timers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            seg_q   <= '0;
            step_q  <= 1'b0;
            dwell_q <= '0;
`ifdef SEG_MSG_BLANK_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
`ifdef SEG_MSG_BLANK_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign seg  = seg_q;
    assign idx  = idx_q;
    assign step = step_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Bench for seg_msg_sequencer: randomized button/auto stimulus, expected
// letters queued by a message-level model, popped by a monitor on each step.
module tb_seg_msg_sequencer;

    localparam logic [15:0] DEB   = 16'd4;
    localparam logic [23:0] DWELL = 24'd10;
`ifdef SEG_MSG_BLANK_GAP_EN
    localparam logic [23:0] GAP      = 24'd3;
    localparam int          PERIOD   = 13;
    localparam int          ZERO_RUN = 3;
`else
    localparam int          PERIOD   = 10;
    localparam int          ZERO_RUN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, btn, auto;
    logic [6:0] seg;
    logic [3:0] idx;
    logic       step;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int step_cnt = 0;
    int last_step_cyc = 0;
    int zero_run = 0;
    bit shown = 1'b0;

    logic [10:0] exp_q[$];
    logic [10:0] exp_v;

    int    m_idx = 0;
    bit    m_shown = 1'b0;
    string MSG = "SEnOLGULGOnUL";

    seg_msg_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL)
`ifdef SEG_MSG_BLANK_GAP_EN
        ,
        .GAP_CYCLES      (GAP)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .auto (auto),
        .seg  (seg),
        .idx  (idx),
        .step (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] letter_seg(input byte c);
        case (c)
            "S": return 7'b1011011;
            "E": return 7'b1001111;
            "n": return 7'b0010101;
            "O": return 7'b1111110;
            "L": return 7'b0001110;
            "G": return 7'b1011110;
            "U": return 7'b0111110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // One advance of the message: first after reset shows letter 0, else next with wrap.
    task automatic expect_adv();
        if (!m_shown) begin
            m_idx   = 0;
            m_shown = 1'b1;
        end else begin
            m_idx = (m_idx + 1) % 13;
        end
        exp_q.push_back({4'(m_idx), letter_seg(MSG[m_idx])});
    endtask

    // Monitor: each step pops one expected letter; blank cycles between letters are counted.
    always @(negedge clk) begin
        if (rst) begin
            shown    = 1'b0;
            zero_run = 0;
        end else if (step) begin
            step_cnt++;
            last_step_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_step", int'({idx, seg}), 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("letter_idx_seg", int'({idx, seg}), int'(exp_v));
            end
            if (shown) check("blank_cycles_between_letters", zero_run, ZERO_RUN);
            shown    = 1'b1;
            zero_run = 0;
        end else if (shown && seg == 7'd0) begin
            zero_run++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_steps(input int target);
        int budget = 300;
        while (step_cnt < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (step_cnt < target) check("step_timeout", step_cnt, target);
    endtask

    task automatic press_bouncy();
        int k;
        k = int'($urandom_range(0, 3));
        repeat (k) begin
            btn = 1'b1; tick(1);
            btn = 1'b0; tick(1);
        end
        btn = 1'b1;
        tick(int'($urandom_range(8, 20)));
        k = int'($urandom_range(0, 3));
        repeat (k) begin
            btn = 1'b0; tick(1);
            btn = 1'b1; tick(1);
        end
        btn = 1'b0;
        tick(int'($urandom_range(8, 20)));
    endtask

    initial begin
        int base;
        int prev;
        rst  = 1'b1;
        btn  = 1'b0;
        auto = 1'b0;
        tick(3);
        check("reset_seg", int'(seg), 0);
        check("reset_idx", int'(idx), 0);
        check("reset_step", int'(step), 0);
        rst = 1'b0;
        tick(5);

        // Clean long press in manual mode, then release and idle.
        expect_adv();
        btn = 1'b1; tick(20);
        btn = 1'b0; tick(20);
        check("steps_after_clean_press", step_cnt, 1);
        tick(30);
        check("manual_display_holds", step_cnt, 1);

        // Bouncy presses step once each; short pulses never step.
        for (int i = 0; i < 12; i++) begin
            expect_adv();
            press_bouncy();
            wait_steps(i + 2);
            if ($urandom_range(0, 1) == 1) begin
                btn = 1'b1;
                tick(int'($urandom_range(1, 3)));
                btn = 1'b0;
                tick(10);
                check("short_pulse_no_step", step_cnt, i + 2);
            end
        end

        // Auto scroll from index 12 with wrap to 0.
        base = step_cnt;
        repeat (4) expect_adv();
        auto = 1'b1;
        wait_steps(base + 1);
        prev = last_step_cyc;
        for (int i = 2; i <= 4; i++) begin
            wait_steps(base + i);
            check("auto_period", last_step_cyc - prev, PERIOD);
            prev = last_step_cyc;
        end

        // Press event timed to land on the dwell-expiry cycle.
        expect_adv();
        while (cyc < prev + 3) tick(1);
        btn = 1'b1;
        wait_steps(base + 5);
        check("coincident_press_period", last_step_cyc - prev, PERIOD);
        prev = last_step_cyc;
        expect_adv();
        wait_steps(base + 6);
        check("timer_restart_period", last_step_cyc - prev, PERIOD);
        prev = last_step_cyc;
        tick(1);
        btn = 1'b0;

`ifdef SEG_MSG_BLANK_GAP_EN
        expect_adv();
        wait_steps(base + 7);
        check("gap_auto_period", last_step_cyc - prev, PERIOD);
        prev = last_step_cyc;
        // Press event lands inside the blank gap and must be dropped.
        expect_adv();
        while (cyc < prev + 5) tick(1);
        btn = 1'b1;
        wait_steps(base + 8);
        check("press_in_gap_period", last_step_cyc - prev, PERIOD);
        prev = last_step_cyc;
        tick(1);
        btn = 1'b0;
        expect_adv();
        wait_steps(base + 9);
        check("after_gap_press_period", last_step_cyc - prev, PERIOD);
        tick(1);
`endif

        // Reset in the middle of a dwell.
        tick(4);
        rst  = 1'b1;
        auto = 1'b0;
        #1;
        check("midreset_seg", int'(seg), 0);
        check("midreset_idx", int'(idx), 0);
        check("midreset_step", int'(step), 0);
        m_shown = 1'b0;
        base = step_cnt;
        tick(3);
        rst = 1'b0;
        tick(20);
        check("no_step_after_reset", step_cnt, base);
        expect_adv();
        btn = 1'b1; tick(20);
        btn = 1'b0; tick(20);
        wait_steps(base + 1);
        check("steps_after_reset_press", step_cnt, base + 1);
        check("pending_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
